sync_gray_ptr: RTL and testbench
================================

// Module: sync_gray_ptr
// PURPOSE
//  Parametrised gray-coded pointer synchroniser for the async FIFO; next generation of
//  the fixed 2-flop r2w/w2r synchroniser. Brings a gray pointer from the foreign clock
//  domain into the local one through SYNC_STAGES flops, then provides the registered
//  binary equivalent, a per-cycle advance pulse and an advance count to local logic.
//  Instantiated once per direction (read pointer into wclk, write pointer into rclk).
// PARAMETERS
//  ADDR_WIDTH   4  pointer width in bits, including the wrap bit; legal range >=2
//  SYNC_STAGES  2  synchroniser flop count; legal range >=2 (elaboration error if <2)
// PORTS
//  wclk         in   1           local (destination) clock
//  wrst_n       in   1           asynchronous, active-low reset
//  ptr_gray_in  in   ADDR_WIDTH  gray pointer from foreign domain (asynchronous to wclk)
//  q_gray       out  ADDR_WIDTH  synchronised gray pointer (last sync stage)
//  q_bin        out  ADDR_WIDTH  registered binary conversion of q_gray
//  adv_pulse    out  1           high for one cycle when q_bin changes value
//  adv_cnt      out  ADDR_WIDTH  (new q_bin - old q_bin) mod 2**ADDR_WIDTH, valid with adv_pulse
//  err_clr      in   1           synchronous clear of err_multi_bit
//  err_multi_bit out 1           sticky: synchronised gray changed by >1 bit in one cycle
// BEHAVIOUR
//  - Interface: one clock, wclk; reset wrst_n is asynchronous, active-low.
//  - Reset: all sync stages, q_gray, q_bin, previous-value registers, adv_cnt = 0;
//    adv_pulse = 0; err_multi_bit = 0. Asserting wrst_n mid-operation clears all state
//    immediately (async); first post-reset edge resamples ptr_gray_in into stage 1.
//  - Sync chain: stage[0] <= ptr_gray_in; stage[i] <= stage[i-1]; q_gray = stage[SYNC_STAGES-1].
//    Only stage[0] may go metastable; no logic taps any stage other than the last.
//  - Latency: input change visible on q_gray after SYNC_STAGES wclk rising edges;
//    on q_bin / adv_pulse / adv_cnt after SYNC_STAGES+1 edges.
//  - Conversion: bin[MSB] = gray[MSB]; bin[i] = bin[i+1] ^ gray[i]; result registered.
//  - Advance: q_bin_prev holds q_bin of the prior cycle. adv_pulse = (q_bin != q_bin_prev),
//    registered together with q_bin; adv_cnt = q_bin - q_bin_prev truncated to
//    ADDR_WIDTH bits, held 0 when adv_pulse = 0.
//  - Wrap-around: modular subtraction; q_bin 15 -> 0 (ADDR_WIDTH=4) gives adv_cnt = 1.
//  - Multiple foreign advances between local samples (fast foreign clock): adv_cnt
//    reports the full modular delta in one pulse; no advance is lost.
//  - Backward movement is not detected; delta is reported modulo 2**ADDR_WIDTH.
//  - Stable input: adv_pulse stays 0, q_gray/q_bin hold.
// CONFIGURATION
//  GRAY_CHECK_EN defined: q_gray_prev register; err_multi_bit set on the cycle after
//    popcount(q_gray ^ q_gray_prev) > 1; stays set until err_clr sampled high or reset;
//    simultaneous set and err_clr -> set wins (flag stays 1).
//  GRAY_CHECK_EN undefined: checker logic absent; err_multi_bit tied 0; err_clr ignored.
//    All other behaviour identical; ports are present in both builds.
// TESTING
//  1 Reset: hold wrst_n=0, ptr_gray_in=4'b1010 -> all outputs 0; release, input stable
//    -> q_gray=1010 after 2 edges, q_bin=1100 after 3, one adv_pulse with adv_cnt=12.
//  2 Single steps: drive gray sequence 0..15 one value per 4 wclk -> 16 adv_pulses each
//    adv_cnt=1, including wrap 15->0 (gray 1000 -> 0000).
//  3 Burst: change input gray 0011 -> 0110 (bin 2 -> 4) within one wclk -> single
//    adv_pulse, adv_cnt=2; with GRAY_CHECK_EN err_multi_bit=1, err_clr pulse -> 0.
//  4 SYNC_STAGES=3, ADDR_WIDTH=6: step input -> q_gray after exactly 3 edges, q_bin after 4.
//  5 Mid-operation reset: assert wrst_n between edges during stepping -> outputs 0
//    asynchronously, no adv_pulse on release until input resampled through chain.
//  6 Without GRAY_CHECK_EN: repeat scenario 3 -> err_multi_bit stays 0, adv_cnt=2.

Source files
------------

// File: rtl/sync_gray_ptr.sv
// Gray-coded pointer synchroniser: SYNC_STAGES-flop chain, registered binary view, advance pulse/count.
// Define GRAY_CHECK_EN to build the sticky multi-bit-change detector behind err_multi_bit.
module sync_gray_ptr #(
    parameter int ADDR_WIDTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic [ADDR_WIDTH-1:0] ptr_gray_in,
    output logic [ADDR_WIDTH-1:0] q_gray,
    output logic [ADDR_WIDTH-1:0] q_bin,
    output logic                  adv_pulse,
    output logic [ADDR_WIDTH-1:0] adv_cnt,
    input  logic                  err_clr,
    output logic                  err_multi_bit
);

    generate
        if (SYNC_STAGES < 2) begin : g_bad_stages
            $error("sync_gray_ptr: SYNC_STAGES must be >= 2");
        end
        if (ADDR_WIDTH < 2) begin : g_bad_width
            $error("sync_gray_ptr: ADDR_WIDTH must be >= 2");
        end
    endgenerate

    // Only sync_q[0] can go metastable; nothing but the last stage is tapped.
    logic [ADDR_WIDTH-1:0] sync_q [SYNC_STAGES];

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= ptr_gray_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_gray = sync_q[SYNC_STAGES-1];

    logic [ADDR_WIDTH-1:0] bin_next;

    always_comb begin
        bin_next = '0;
        for (int i = 0; i < ADDR_WIDTH; i++) begin
            bin_next[i] = ^(q_gray >> i);
        end
    end

    // q_bin is the previous-cycle binary value relative to bin_next, so pulse and count
    // land on the same edge as the new q_bin.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            q_bin     <= '0;
            adv_pulse <= 1'b0;
            adv_cnt   <= '0;
        end else begin
            q_bin     <= bin_next;
            adv_pulse <= (bin_next != q_bin);
            adv_cnt   <= (bin_next != q_bin) ? (bin_next - q_bin) : '0;
        end
    end

`ifdef GRAY_CHECK_EN
    logic [ADDR_WIDTH-1:0] q_gray_prev;
    logic                  err_q;

    // Set has priority over clear so a violation coinciding with err_clr is not lost.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            q_gray_prev <= '0;
            err_q       <= 1'b0;
        end else begin
            q_gray_prev <= q_gray;
            if ($countones(q_gray ^ q_gray_prev) > 1) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    assign err_multi_bit = err_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err_multi_bit  = 1'b0;
`endif

endmodule

// File: tb/tb_sync_gray_ptr.sv
// Bench for sync_gray_ptr: default instance (4-bit, 2 stages) and a 6-bit, 3-stage instance,
// checked every cycle against a sample-history model plus directed literal expectations.
module tb_sync_gray_ptr;

    logic       wclk = 1'b0;
    logic       wrst_n;
    logic [3:0] gray_a;
    logic [5:0] gray_b;
    logic       clr_a;
    logic       clr_b;

    logic [3:0] q_gray_a, q_bin_a, adv_cnt_a;
    logic       adv_pulse_a, err_a;
    logic [5:0] q_gray_b, q_bin_b, adv_cnt_b;
    logic       adv_pulse_b, err_b;

`ifdef GRAY_CHECK_EN
    localparam bit GC = 1'b1;
`else
    localparam bit GC = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 wclk = ~wclk;

    sync_gray_ptr dut_a (
        .wclk          (wclk),
        .wrst_n        (wrst_n),
        .ptr_gray_in   (gray_a),
        .q_gray        (q_gray_a),
        .q_bin         (q_bin_a),
        .adv_pulse     (adv_pulse_a),
        .adv_cnt       (adv_cnt_a),
        .err_clr       (clr_a),
        .err_multi_bit (err_a)
    );

    sync_gray_ptr #(.ADDR_WIDTH(6), .SYNC_STAGES(3)) dut_b (
        .wclk          (wclk),
        .wrst_n        (wrst_n),
        .ptr_gray_in   (gray_b),
        .q_gray        (q_gray_b),
        .q_bin         (q_bin_b),
        .adv_pulse     (adv_pulse_b),
        .adv_cnt       (adv_cnt_b),
        .err_clr       (clr_b),
        .err_multi_bit (err_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Binary value of a gray code is the XOR of all its right shifts.
    function automatic logic [7:0] g2b(input logic [7:0] g);
        logic [7:0] b;
        b = g;
        for (int s = 1; s < 8; s++) begin
            b = b ^ (g >> s);
        end
        return b;
    endfunction

    // Model: history of sampled inputs, newest first; index j = sample taken j edges ago.
    logic [7:0] hist_a[$];
    logic [7:0] hist_b[$];
    logic [7:0] exp_qg_a = 0, exp_qb_a = 0, exp_cnt_a = 0, prev_a;
    logic [7:0] exp_qg_b = 0, exp_qb_b = 0, exp_cnt_b = 0, prev_b;
    logic       exp_pulse_a = 0, exp_err_a = 0, exp_pulse_b = 0, exp_err_b = 0;

    always @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            hist_a = {};
            hist_b = {};
            repeat (4) hist_a.push_back(8'h00);
            repeat (5) hist_b.push_back(8'h00);
            exp_qg_a = 0; exp_qb_a = 0; exp_cnt_a = 0; exp_pulse_a = 0; exp_err_a = 0;
            exp_qg_b = 0; exp_qb_b = 0; exp_cnt_b = 0; exp_pulse_b = 0; exp_err_b = 0;
        end else begin
            hist_a.push_front({4'h0, gray_a});
            void'(hist_a.pop_back());
            hist_b.push_front({2'b00, gray_b});
            void'(hist_b.pop_back());
            exp_qg_a    = hist_a[1];
            exp_qb_a    = g2b(hist_a[2]);
            prev_a      = g2b(hist_a[3]);
            exp_pulse_a = (exp_qb_a != prev_a);
            exp_cnt_a   = exp_pulse_a ? ((exp_qb_a - prev_a) & 8'h0F) : 8'h00;
            exp_qg_b    = hist_b[2];
            exp_qb_b    = g2b(hist_b[3]);
            prev_b      = g2b(hist_b[4]);
            exp_pulse_b = (exp_qb_b != prev_b);
            exp_cnt_b   = exp_pulse_b ? ((exp_qb_b - prev_b) & 8'h3F) : 8'h00;
            if (GC) begin
                if ($countones(hist_a[2] ^ hist_a[3]) > 1) exp_err_a = 1'b1;
                else if (clr_a) exp_err_a = 1'b0;
                if ($countones(hist_b[3] ^ hist_b[4]) > 1) exp_err_b = 1'b1;
                else if (clr_b) exp_err_b = 1'b0;
            end
        end
    end

    always @(negedge wclk) begin
        chk("a_q_gray",    32'(q_gray_a),    32'(exp_qg_a));
        chk("a_q_bin",     32'(q_bin_a),     32'(exp_qb_a));
        chk("a_adv_pulse", 32'(adv_pulse_a), 32'(exp_pulse_a));
        chk("a_adv_cnt",   32'(adv_cnt_a),   32'(exp_cnt_a));
        chk("a_err",       32'(err_a),       32'(exp_err_a));
        chk("b_q_gray",    32'(q_gray_b),    32'(exp_qg_b));
        chk("b_q_bin",     32'(q_bin_b),     32'(exp_qb_b));
        chk("b_adv_pulse", 32'(adv_pulse_b), 32'(exp_pulse_b));
        chk("b_adv_cnt",   32'(adv_cnt_b),   32'(exp_cnt_b));
        chk("b_err",       32'(err_b),       32'(exp_err_b));
    end

    task automatic edge_n_settle();
        @(posedge wclk);
        #1;
    endtask

    initial begin
        int         pulses;
        logic [3:0] v;

        wrst_n = 1'b0;
        gray_a = 4'b1010;
        gray_b = 6'b0;
        clr_a  = 1'b0;
        clr_b  = 1'b0;

        // Reset held with a non-zero input
        repeat (3) @(negedge wclk);
        chk("t1_rst_q_gray", 32'(q_gray_a), 32'h0);
        chk("t1_rst_q_bin",  32'(q_bin_a),  32'h0);
        chk("t1_rst_pulse",  32'(adv_pulse_a), 32'h0);
        chk("t1_rst_cnt",    32'(adv_cnt_a), 32'h0);
        chk("t1_rst_err",    32'(err_a), 32'h0);
        wrst_n = 1'b1;
        edge_n_settle();
        chk("t1_e1_q_gray", 32'(q_gray_a), 32'h0);
        edge_n_settle();
        chk("t1_e2_q_gray", 32'(q_gray_a), 32'hA);
        chk("t1_e2_q_bin",  32'(q_bin_a),  32'h0);
        edge_n_settle();
        chk("t1_e3_q_bin",  32'(q_bin_a),  32'hC);
        chk("t1_e3_pulse",  32'(adv_pulse_a), 32'h1);
        chk("t1_e3_cnt",    32'(adv_cnt_a), 32'd12);
        edge_n_settle();
        chk("t1_e4_pulse",  32'(adv_pulse_a), 32'h0);
        chk("t1_e4_cnt",    32'(adv_cnt_a), 32'h0);

        // Single gray steps 13..15,0..12 (includes the 15 -> 0 wrap)
        @(negedge wclk);
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            v = 4'(13 + i);
            gray_a = v ^ (v >> 1);
            repeat (4) begin
                @(negedge wclk);
                if (adv_pulse_a) begin
                    pulses++;
                    chk("t2_step_cnt", 32'(adv_cnt_a), 32'h1);
                end
            end
        end
        chk("t2_pulse_count", 32'(pulses), 32'd16);

        // Burst: gray 0011 -> 0110 (bin 2 -> 4) in one local cycle
        gray_a = 4'b0011;
        repeat (5) @(negedge wclk);
        clr_a = 1'b1;
        @(negedge wclk);
        clr_a = 1'b0;
        @(negedge wclk);
        chk("t3_err_before", 32'(err_a), 32'h0);
        gray_a = 4'b0110;
        repeat (3) edge_n_settle();
        chk("t3_pulse", 32'(adv_pulse_a), 32'h1);
        chk("t3_cnt",   32'(adv_cnt_a),   32'h2);
        chk("t3_q_bin", 32'(q_bin_a),     32'h4);
        chk("t3_err",   32'(err_a),       32'(GC));
        edge_n_settle();
        chk("t3_pulse_after", 32'(adv_pulse_a), 32'h0);
        @(negedge wclk);
        clr_a = 1'b1;
        edge_n_settle();
        chk("t3_err_cleared", 32'(err_a), 32'h0);
        @(negedge wclk);
        clr_a = 1'b0;

        // Deeper, wider instance: latency 3 edges to q_gray, 4 to q_bin
        gray_b = 6'b000001;
        repeat (2) edge_n_settle();
        chk("t4_e2_q_gray", 32'(q_gray_b), 32'h0);
        edge_n_settle();
        chk("t4_e3_q_gray", 32'(q_gray_b), 32'h1);
        chk("t4_e3_q_bin",  32'(q_bin_b),  32'h0);
        edge_n_settle();
        chk("t4_e4_q_bin",  32'(q_bin_b),  32'h1);
        chk("t4_e4_pulse",  32'(adv_pulse_b), 32'h1);
        chk("t4_e4_cnt",    32'(adv_cnt_b), 32'h1);

        // Reset asserted between clock edges while running
        @(negedge wclk);
        gray_a = 4'b0111;
        @(posedge wclk);
        #3;
        wrst_n = 1'b0;
        #1;
        chk("t5_async_q_gray_a", 32'(q_gray_a), 32'h0);
        chk("t5_async_q_bin_a",  32'(q_bin_a),  32'h0);
        chk("t5_async_err_a",    32'(err_a),    32'h0);
        chk("t5_async_q_gray_b", 32'(q_gray_b), 32'h0);
        chk("t5_async_q_bin_b",  32'(q_bin_b),  32'h0);
        repeat (2) @(negedge wclk);
        wrst_n = 1'b1;
        edge_n_settle();
        chk("t5_e1_pulse",  32'(adv_pulse_a), 32'h0);
        chk("t5_e1_q_gray", 32'(q_gray_a), 32'h0);
        edge_n_settle();
        chk("t5_e2_pulse",  32'(adv_pulse_a), 32'h0);
        chk("t5_e2_q_gray", 32'(q_gray_a), 32'h7);
        // 0000 -> 0111 is a multi-bit change; clear requested on the same edge it is flagged
        clr_a = 1'b1;
        edge_n_settle();
        chk("t5_e3_pulse",  32'(adv_pulse_a), 32'h1);
        chk("t5_e3_cnt",    32'(adv_cnt_a), 32'h5);
        chk("t5_e3_q_bin",  32'(q_bin_a), 32'h5);
        chk("t5_set_wins",  32'(err_a), 32'(GC));
        @(negedge wclk);
        clr_a = 1'b0;

        repeat (4) @(negedge wclk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
